// File: rtl/keccak_round_ctrl.sv
// Round/step sequencer for an iterative Keccak-f core: loads the state, then walks
// theta..iota per round with a bounded acknowledge wait, and holds the result until consumed.
//   state | meaning
//   IDLE  | waiting for in_valid, err visible
//   LOAD  | one-cycle capture of the input state
//   THETA..IOTA | step unit started (go on first cycle), waiting for step_ack
//   DONE  | permuted state presented until out_ready
module keccak_round_ctrl #(
  parameter int ROUNDS      = 24,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [4:0] step_go,
  input  logic       step_ack,
  output logic       state_we,
  output logic [2:0] state_sel,
  output logic [4:0] round_idx,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_THETA = 3'd2,
    S_RHO   = 3'd3,
    S_PI    = 3'd4,
    S_CHI   = 3'd5,
    S_IOTA  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);
  localparam logic [9:0] WAIT_LAST  = 10'(ACK_TIMEOUT - 1);

  state_t     state, state_nx;
  logic [9:0] wait_cnt;
  logic [2:0] step_code;
  logic       in_step;
  logic       accept;
  logic       timeout;
  logic       round_inc;
  logic       round_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    step_go   = 5'd0;
    state_we  = 1'b0;
    state_sel = 3'd0;
    out_valid = 1'b0;
    busy      = 1'b1;
    in_step   = 1'b0;
    step_code = 3'd0;
    accept    = 1'b0;
    timeout   = 1'b0;
    round_inc = 1'b0;
    round_clr = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        state_we  = 1'b1;
        state_sel = 3'd0;
        state_nx  = S_THETA;
      end
      S_THETA, S_RHO, S_PI, S_CHI, S_IOTA: begin
        in_step = 1'b1;
        // step states are encoded consecutively, so the source-select code is state-1
        step_code = state - 3'd1;
        if (wait_cnt == 10'd0) step_go = 5'd1 << (step_code - 3'd1);
        if (step_ack) begin
          state_we  = 1'b1;
          state_sel = step_code;
          if (state == S_IOTA) begin
            if (round_idx == LAST_ROUND) begin
              state_nx = S_DONE;
            end else begin
              round_inc = 1'b1;
              state_nx  = S_THETA;
            end
          end else begin
            state_nx = state_t'(state + 3'd1);
          end
        end else if (wait_cnt == WAIT_LAST) begin
          timeout  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          round_clr = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // every transition out of a step state is a fresh step entry, so the wait restarts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= 10'd0;
      round_idx <= 5'd0;
      err       <= 1'b0;
    end else begin
      if (in_step && (state_nx == state)) wait_cnt <= wait_cnt + 10'd1;
      else                                wait_cnt <= 10'd0;

      if (accept || timeout || round_clr) round_idx <= 5'd0;
      else if (round_inc)                 round_idx <= round_idx + 5'd1;

      if (timeout)     err <= 1'b1;
      else if (accept) err <= 1'b0;
    end
  end

endmodule
